rr_burst_arbiter8: RTL and testbench
====================================

Name: rr_burst_arbiter8

Overview:
- Round-robin arbiter with burst locking that shares one 8:1 W-bit selection datapath among 8 requesters.
- Picks one requester and drives the 3-bit select for the shared mux.
- Holds the grant until the granted requester's last beat is accepted downstream, then rotates priority.
- Sits between 8 producer ports and a single downstream consumer with a valid/ready handshake.

Parameters:
- W, default 8, data width per requester and of the output bus. The requester count is fixed at 8, so the select is 3 bits.

Ports:
- clock  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- io_req  input  8  per-requester valid; bit i = requester i has a beat
- io_last  input  8  per-requester last-beat flag; qualified by io_req[i]
- io_data  input  8*W  packed requester data; slice i = bits [i*W+W-1 : i*W]
- io_in_ready  output  8  per-requester ready; at most one bit set
- io_out_valid  output  1  downstream valid
- io_out_ready  input  1  downstream ready
- io_out_bits  output  W  data of the granted requester
- io_out_last  output  1  last flag of the granted requester
- io_out_sel  output  3  registered index of the current or most recent grant
- io_busy  output  1  1 while in BUSY

Behaviour:
Reset values and state:
- Registers are state (IDLE/BUSY), ptr[2:0] (highest-priority index), sel[2:0].
- Reset, sampled at the clock edge, forces state=IDLE, ptr=0, sel=0.
- Reset overrides everything, including a burst in progress: the partial burst is abandoned with no completion.

IDLE state:
- io_out_valid=0, io_in_ready=0, io_busy=0, io_out_bits=0, io_out_last=0.
- If io_req!=0, pick the first requester i with io_req[i]=1, scanning ptr, ptr+1, ..., ptr+7 mod 8 (wrap-around).
- Then sel<=i, state<=BUSY.
- If io_req==0, remain in IDLE.

BUSY state:
- io_busy=1.
- io_out_valid=io_req[sel], io_out_bits=io_data slice sel, io_out_last=io_last[sel].
- io_in_ready[sel]=io_out_ready; all other bits are 0.
- Handshake (accept) = io_out_valid & io_out_ready.
- Accept with io_out_last=1: state<=IDLE, ptr<=sel+1 mod 8 (7 wraps to 0).
- Accept with io_out_last=0: stay in BUSY; the grant stays locked.
- Granted requester deasserts io_req mid-burst: io_out_valid=0, stay in BUSY, lock held. There is no timeout.
- Requests from other ports during BUSY are ignored; their io_in_ready stays 0.

Timing:
- Grant latency is 1 cycle: a request seen in IDLE at edge k gives io_out_valid at cycle k+1.
- There is one mandatory IDLE bubble cycle between bursts.
- Single-beat transfer: io_last=1 on the first beat.

Combinational rules:
- Output data, valid, last and ready are combinational from registered sel/state and the current inputs. There is no data register, so there is no buffering.
- io_out_sel is always the registered sel and is stable for the whole burst.
- The rotation scan is an 8-way priority search on the request vector rotated by ptr.

Test Plan:
- After reset, io_req=8'h00 for 5 cycles -> io_busy=0, io_out_valid=0, io_in_ready=0, io_out_sel=0.
- io_req=8'h81, io_last=8'hFF, io_out_ready=1, ptr=0 -> requester 0 granted (sel=0) first, then IDLE bubble, then requester 7 (sel=7); ptr ends at 0 (wrap).
- All 8 requesting continuously, io_last=8'hFF, io_out_ready=1 -> grants in order 0,1,...,7,0, one every 2 cycles; no requester is skipped or repeated.
- Requester 3 alone, 4-beat burst (io_last[3] high on beat 4), io_out_ready toggling 1,0,1,0... -> io_out_sel=3 throughout; a request from requester 5 raised mid-burst is not granted until after beat 4 is accepted; then ptr=4 and requester 5 is granted next.
- Requester 2 in BUSY drops io_req for 3 cycles mid-burst -> io_out_valid=0 during the gap, io_busy=1, sel=2 retained; the burst resumes when io_req[2] returns.
- reset=1 for one cycle mid-burst of requester 6 -> next cycle state=IDLE, ptr=0, sel=0, io_in_ready=0; with requesters 6 and 1 both requesting, requester 1 wins.

Source files
------------

// File: rtl/rr_burst_arbiter8.sv
// +--------------------------------------------------------------------------+
// | rr_burst_arbiter8 : 8-way round-robin arbiter with burst lock, W-bit mux  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module rr_burst_arbiter8 #(
  parameter int W = 8
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [7:0]     io_req,
  input  logic [7:0]     io_last,
  input  logic [8*W-1:0] io_data,
  output logic [7:0]     io_in_ready,
  output logic           io_out_valid,
  input  logic           io_out_ready,
  output logic [W-1:0]   io_out_bits,
  output logic           io_out_last,
  output logic [2:0]     io_out_sel,
  output logic           io_busy
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] sel_q, sel_d;

  logic [15:0] w_req_dbl;
  logic [7:0]  w_req_rot;
  logic [2:0]  w_pick_off;
  logic        w_accept;

  // Request vector rotated so bit 0 is the current highest-priority requester.
  assign w_req_dbl = {io_req, io_req};
  assign w_req_rot = w_req_dbl[ptr_q +: 8];

  always_comb begin
    w_pick_off = 3'd0;
    for (int j = 7; j >= 0; j--) begin
      if (w_req_rot[j]) w_pick_off = 3'(j);
    end
  end

  always_comb begin
    io_out_valid = 1'b0;
    io_out_bits  = '0;
    io_out_last  = 1'b0;
    io_in_ready  = 8'h00;
    if (state_q == BUSY) begin
      io_out_valid       = io_req[sel_q];
      io_out_bits        = io_data[int'(sel_q)*W +: W];
      io_out_last        = io_last[sel_q];
      io_in_ready[sel_q] = io_out_ready;
    end
  end

  assign w_accept   = io_out_valid & io_out_ready;
  assign io_out_sel = sel_q;
  assign io_busy    = (state_q == BUSY);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (io_req != 8'h00) begin
          sel_d   = ptr_q + w_pick_off;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (w_accept && io_out_last) begin
          ptr_d   = sel_q + 3'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      sel_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rr_burst_arbiter8.sv
// +--------------------------------------------------------------------------+
// | tb_rr_burst_arbiter8 : directed self-checking bench for rr_burst_arbiter8 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_rr_burst_arbiter8;

  localparam int W = 8;

  logic           clock;
  logic           reset;
  logic [7:0]     io_req;
  logic [7:0]     io_last;
  logic [8*W-1:0] io_data;
  logic [7:0]     io_in_ready;
  logic           io_out_valid;
  logic           io_out_ready;
  logic [W-1:0]   io_out_bits;
  logic           io_out_last;
  logic [2:0]     io_out_sel;
  logic           io_busy;

  int total;
  int bad;

  rr_burst_arbiter8 #(.W(W)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_req       (io_req),
    .io_last      (io_last),
    .io_data      (io_data),
    .io_in_ready  (io_in_ready),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_out_bits  (io_out_bits),
    .io_out_last  (io_out_last),
    .io_out_sel   (io_out_sel),
    .io_busy      (io_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"},  32'(io_busy),      32'd0);
    chk({tag, "_valid"}, 32'(io_out_valid), 32'd0);
    chk({tag, "_ready"}, 32'(io_in_ready),  32'h00);
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    reset        = 1'b1;
    io_req       = 8'h00;
    io_last      = 8'h00;
    io_out_ready = 1'b0;
    for (int i = 0; i < 8; i++) io_data[i*W +: W] = 8'hA0 | 8'(i);
    tick();
    tick();
    reset = 1'b0;

    // Quiet after reset
    for (int c = 0; c < 5; c++) begin
      chk_idle("rst_idle");
      chk("rst_sel",  32'(io_out_sel),  32'd0);
      chk("rst_bits", 32'(io_out_bits), 32'd0);
      tick();
    end

    // Requesters 0 and 7, single beats, ptr starts at 0
    io_req = 8'h81; io_last = 8'hFF; io_out_ready = 1'b1;
    #1;
    chk("t2_idle_valid", 32'(io_out_valid), 32'd0);
    tick();
    chk("t2_sel0",   32'(io_out_sel),   32'd0);
    chk("t2_bits0",  32'(io_out_bits),  32'hA0);
    chk("t2_rdy0",   32'(io_in_ready),  32'h01);
    chk("t2_valid0", 32'(io_out_valid), 32'd1);
    chk("t2_last0",  32'(io_out_last),  32'd1);
    tick();
    chk_idle("t2_bubble");
    tick();
    chk("t2_sel7",  32'(io_out_sel),  32'd7);
    chk("t2_bits7", 32'(io_out_bits), 32'hA7);
    chk("t2_rdy7",  32'(io_in_ready), 32'h80);
    tick();
    chk_idle("t2_bubble2");

    // All eight requesting: strict rotation starting at 0 (ptr wrapped)
    io_req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      tick();
      chk("t3_sel",  32'(io_out_sel),  32'(k % 8));
      chk("t3_busy", 32'(io_busy),     32'd1);
      chk("t3_rdy",  32'(io_in_ready), 32'(8'h01 << (k % 8)));
      tick();
      chk("t3_bubble", 32'(io_busy), 32'd0);
    end

    // Requester 3, 4-beat burst, ready toggling; requester 5 arrives mid-burst
    io_req = 8'h08; io_last = 8'h00; io_out_ready = 1'b0;
    tick();
    chk("t4_sel", 32'(io_out_sel), 32'd3);
    io_out_ready = 1'b1;
    #1;
    chk("t4_rdy_b1",   32'(io_in_ready),  32'h08);
    chk("t4_valid_b1", 32'(io_out_valid), 32'd1);
    tick();
    io_out_ready = 1'b0; io_req = 8'h28;
    #1;
    chk("t4_rdy_stall", 32'(io_in_ready), 32'h00);
    chk("t4_sel_stall", 32'(io_out_sel),  32'd3);
    tick();
    io_out_ready = 1'b1;
    #1;
    chk("t4_rdy_b2", 32'(io_in_ready), 32'h08);
    chk("t4_last_b2", 32'(io_out_last), 32'd0);
    tick();
    io_out_ready = 1'b0;
    tick();
    io_out_ready = 1'b1;
    tick();
    io_out_ready = 1'b0;
    tick();
    io_out_ready = 1'b1; io_last = 8'h08;
    #1;
    chk("t4_last_b4", 32'(io_out_last), 32'd1);
    chk("t4_sel_b4",  32'(io_out_sel),  32'd3);
    chk("t4_busy_b4", 32'(io_busy),     32'd1);
    tick();
    chk_idle("t4_bubble");
    io_last = 8'hFF;
    tick();
    chk("t4_sel5",  32'(io_out_sel),  32'd5);
    chk("t4_bits5", 32'(io_out_bits), 32'hA5);
    tick();
    chk_idle("t4_end");

    // Requester 2 drops its request for 3 cycles mid-burst (ptr=6)
    io_req = 8'h04; io_last = 8'h00; io_out_ready = 1'b1;
    tick();
    chk("t5_sel",   32'(io_out_sel),   32'd2);
    chk("t5_valid", 32'(io_out_valid), 32'd1);
    tick();
    io_req = 8'h00;
    for (int g = 0; g < 3; g++) begin
      #1;
      chk("t5_gap_valid", 32'(io_out_valid), 32'd0);
      chk("t5_gap_busy",  32'(io_busy),      32'd1);
      chk("t5_gap_sel",   32'(io_out_sel),   32'd2);
      tick();
    end
    io_req = 8'h04; io_last = 8'h04;
    #1;
    chk("t5_resume_valid", 32'(io_out_valid), 32'd1);
    chk("t5_resume_last",  32'(io_out_last),  32'd1);
    chk("t5_resume_bits",  32'(io_out_bits),  32'hA2);
    tick();
    chk_idle("t5_end");

    // Reset in the middle of requester 6's burst (ptr=3)
    io_req = 8'h40; io_last = 8'h00; io_out_ready = 1'b1;
    tick();
    chk("t6_sel6", 32'(io_out_sel), 32'd6);
    tick();
    reset = 1'b1;
    tick();
    reset  = 1'b0;
    io_req = 8'h42;
    #1;
    chk_idle("t6_after_rst");
    chk("t6_sel_rst", 32'(io_out_sel), 32'd0);
    tick();
    chk("t6_winner",      32'(io_out_sel),  32'd1);
    chk("t6_winner_bits", 32'(io_out_bits), 32'hA1);
    chk("t6_winner_rdy",  32'(io_in_ready), 32'h02);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
